// File: rtl/bus_responder.sv
// bus_responder: single-target memory-mapped responder with a word-addressed
// internal memory, programmable response latency, read back-pressure and
// abort handling. Optional build macro BUS_RESPONDER_ERR_EN adds a BUS_err
// output that flags out-of-range or misaligned accesses.
module bus_responder #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_LOG2  = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  BUS_valid,
    input  logic                  BUS_mode,
    input  logic [ADDR_WIDTH-1:0] BUS_addr,
    input  logic [DATA_WIDTH-1:0] BUS_wdata,
    output logic                  BUS_wready,
    output logic [DATA_WIDTH-1:0] BUS_rdata,
    output logic                  BUS_rvalid,
    input  logic                  BUS_rready,
`ifdef BUS_RESPONDER_ERR_EN
    output logic                  BUS_err,
`endif
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    // Byte span of the memory window (4 bytes per word)
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES =
        {{(ADDR_WIDTH-DEPTH_LOG2-3){1'b0}}, 1'b1, {(DEPTH_LOG2+2){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRESP = 3'd2,
        ST_RRESP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wready_q, wready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   addr_sel_s;
    logic [ADDR_WIDTH-1:0]   offset_s;
    logic                    in_range_s;
    logic                    ok_s;
    logic [DEPTH_LOG2-1:0]   idx_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    // Address decode: live bus address while idle, latched address afterwards
    always_comb begin
        if (state_q == ST_IDLE) begin
            addr_sel_s = BUS_addr;
        end else begin
            addr_sel_s = addr_q;
        end
        offset_s   = addr_sel_s - BASE_ADDR;
        in_range_s = (addr_sel_s >= BASE_ADDR) && (offset_s < MEM_BYTES);
        idx_s      = offset_s[DEPTH_LOG2+1:2];
`ifdef BUS_RESPONDER_ERR_EN
        ok_s       = in_range_s && (addr_sel_s[1:0] == 2'b00);
`else
        ok_s       = in_range_s;
`endif
        if (ok_s) begin
            rd_word_s = mem_q[idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (BUS_valid) begin
                    addr_d  = BUS_addr;
                    mode_d  = BUS_mode;
                    wdata_d = BUS_wdata;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_INIT != 4'd0) begin
                        state_d = ST_WAIT;
                    end else if (BUS_mode) begin
                        state_d = ST_WRESP;
                    end else begin
                        state_d = ST_RRESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!BUS_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d = 4'd0;
                    if (mode_q) begin
                        state_d = ST_WRESP;
                    end else begin
                        state_d = ST_RRESP;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WRESP: begin
                state_d = ST_DONE;
            end
            ST_RRESP: begin
                if (!BUS_valid) begin
                    state_d = ST_IDLE;
                end else if (BUS_rready) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RRESP;
                end
            end
            ST_DONE: begin
                if (!BUS_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are derived from the state being entered so they register cleanly
        wready_d = (state_d == ST_WRESP);
        rvalid_d = (state_d == ST_RRESP);
        busy_d   = (state_d != ST_IDLE);
        if (rvalid_d) begin
            rdata_d = rd_word_s;
        end else begin
            rdata_d = '0;
        end
        err_d = (wready_d || rvalid_d) && !ok_s;
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            mode_q   <= 1'b0;
            wdata_q  <= '0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            mode_q   <= mode_d;
            wdata_q  <= wdata_d;
            wready_q <= wready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Memory update on the edge closing the acknowledge cycle; reset never touches contents
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_WRESP) && ok_s) begin
            mem_q[idx_s] <= wdata_q;
        end
    end

    assign BUS_wready = wready_q;
    assign BUS_rvalid = rvalid_q;
    assign BUS_rdata  = rdata_q;
    assign busy       = busy_q;
`ifdef BUS_RESPONDER_ERR_EN
    assign BUS_err    = err_q;
`else
    logic err_unused_s;
    assign err_unused_s = err_q;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder: one instance with the
// default latency (2) and one with zero latency.
module tb_bus_responder;

    logic        clk;
    logic        rst;
    logic        valid, mode, rready;
    logic [31:0] addr, wdata;
    logic        wready, rvalid, bsy;
    logic [31:0] rdata;
    logic        err;
    logic        valid0, mode0, rready0;
    logic [31:0] addr0, wdata0;
    logic        wready0, rvalid0, bsy0;
    logic [31:0] rdata0;
    logic        err0;

    int tests = 0;
    int fails = 0;

    bus_responder #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .BUS_valid(valid), .BUS_mode(mode),
        .BUS_addr(addr), .BUS_wdata(wdata), .BUS_wready(wready),
        .BUS_rdata(rdata), .BUS_rvalid(rvalid), .BUS_rready(rready),
`ifdef BUS_RESPONDER_ERR_EN
        .BUS_err(err),
`endif
        .busy(bsy)
    );

    bus_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .BUS_valid(valid0), .BUS_mode(mode0),
        .BUS_addr(addr0), .BUS_wdata(wdata0), .BUS_wready(wready0),
        .BUS_rdata(rdata0), .BUS_rvalid(rvalid0), .BUS_rready(rready0),
`ifdef BUS_RESPONDER_ERR_EN
        .BUS_err(err0),
`endif
        .busy(bsy0)
    );

`ifndef BUS_RESPONDER_ERR_EN
    assign err  = 1'b0;
    assign err0 = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full write with BUS_valid held for 6 cycles; returns number of wready pulses
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int pulses);
        pulses = 0;
        valid = 1'b1; mode = 1'b1; addr = a; wdata = d; rready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wready) pulses++;
        end
        valid = 1'b0;
        tick();
    endtask

    // Read with rready high; captures the first valid data word and err flag
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic e,
                           output logic got);
        got = 1'b0; d = 32'hxxxx_xxxx; e = 1'b0;
        valid = 1'b1; mode = 1'b0; addr = a; rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rvalid && !got) begin
                got = 1'b1; d = rdata; e = err;
            end
        end
        valid = 1'b0; rready = 1'b0;
        tick();
    endtask

    initial begin
        int          p;
        logic [31:0] rd;
        logic        e, got;

        rst = 1'b1; valid = 1'b0; mode = 1'b0; addr = 32'h0; wdata = 32'h0; rready = 1'b0;
        valid0 = 1'b0; mode0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; rready0 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_wready", {31'd0, wready}, 32'd0);
        chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_busy", {31'd0, bsy}, 32'd0);

        // Write DEADBEEF to 0x1004, latency 2, then garbage on addr/mode/rready
        valid = 1'b1; mode = 1'b1; addr = 32'h0000_1004; wdata = 32'hDEAD_BEEF;
        tick();                                  // edge 0
        chk("wr_e0_busy", {31'd0, bsy}, 32'd1);
        chk("wr_e0_wready", {31'd0, wready}, 32'd0);
        addr = 32'h0000_1008; mode = 1'b0; wdata = 32'h0; rready = 1'b1;
        tick();                                  // edge 1
        chk("wr_e1_wready", {31'd0, wready}, 32'd0);
        tick();                                  // edge 2
        chk("wr_e2_wready", {31'd0, wready}, 32'd1);
        tick();
        chk("wr_e3_wready", {31'd0, wready}, 32'd0);
        chk("wr_done_busy", {31'd0, bsy}, 32'd1);
        tick(); tick();
        chk("wr_done_no_rewrite", {31'd0, wready}, 32'd0);
        chk("wr_done_no_rvalid", {31'd0, rvalid}, 32'd0);
        valid = 1'b0; rready = 1'b0;
        tick();
        chk("wr_idle_busy", {31'd0, bsy}, 32'd0);

        // Read 0x1004 with back-pressure
        valid = 1'b1; mode = 1'b0; addr = 32'h0000_1004; rready = 1'b0;
        tick(); tick();
        chk("rd_e1_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        chk("rd_e2_rvalid", {31'd0, rvalid}, 32'd1);
        chk("rd_e2_rdata", rdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_hold_rvalid", {31'd0, rvalid}, 32'd1);
            chk("rd_hold_rdata", rdata, 32'hDEAD_BEEF);
        end
        rready = 1'b1;
        tick();
        chk("rd_drop_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rd_drop_rdata", rdata, 32'd0);
        chk("rd_done_busy", {31'd0, bsy}, 32'd1);
        valid = 1'b0; rready = 1'b0;
        tick();
        chk("rd_idle_busy", {31'd0, bsy}, 32'd0);

        // Known contents at both ends of the window and word 2
        do_write(32'h0000_1000, 32'h0101_0101, p);
        chk("wr_1000_pulses", p, 32'd1);
        do_write(32'h0000_13FC, 32'hA5A5_A5A5, p);
        chk("wr_13fc_pulses", p, 32'd1);
        do_write(32'h0000_1008, 32'h0BAD_F00D, p);
        chk("wr_1008_pulses", p, 32'd1);

        // Out-of-range writes are acknowledged but discarded
        do_write(32'h0000_0FFC, 32'h1111_1111, p);
        chk("oor_0ffc_pulses", p, 32'd1);
        do_write(32'h0000_1400, 32'h2222_2222, p);
        chk("oor_1400_pulses", p, 32'd1);
        do_read(32'h0000_1000, rd, e, got);
        chk("rd_1000_got", {31'd0, got}, 32'd1);
        chk("rd_1000_data", rd, 32'h0101_0101);
        do_read(32'h0000_13FC, rd, e, got);
        chk("rd_13fc_data", rd, 32'hA5A5_A5A5);
        do_read(32'h0000_1400, rd, e, got);
        chk("rd_1400_got", {31'd0, got}, 32'd1);
        chk("rd_1400_data", rd, 32'd0);
`ifdef BUS_RESPONDER_ERR_EN
        chk("rd_1400_err", {31'd0, e}, 32'd1);
`endif

        // Misaligned read: low bits ignored, or flagged when errors are enabled
        do_read(32'h0000_1006, rd, e, got);
`ifdef BUS_RESPONDER_ERR_EN
        chk("rd_1006_data", rd, 32'd0);
        chk("rd_1006_err", {31'd0, e}, 32'd1);
`else
        chk("rd_1006_data", rd, 32'hDEAD_BEEF);
`endif

        // Abort a write in WAIT
        valid = 1'b1; mode = 1'b1; addr = 32'h0000_1008; wdata = 32'h1234_5678;
        tick();
        valid = 1'b0;
        tick();
        chk("abort_wr_busy", {31'd0, bsy}, 32'd0);
        chk("abort_wr_wready", {31'd0, wready}, 32'd0);
        tick(); tick();
        chk("abort_wr_wready2", {31'd0, wready}, 32'd0);
        do_read(32'h0000_1008, rd, e, got);
        chk("abort_wr_word2", rd, 32'h0BAD_F00D);

        // Abort a read in RRESP
        valid = 1'b1; mode = 1'b0; addr = 32'h0000_1004; rready = 1'b0;
        tick(); tick(); tick();
        chk("abort_rd_rvalid_hi", {31'd0, rvalid}, 32'd1);
        valid = 1'b0;
        tick();
        chk("abort_rd_rvalid_lo", {31'd0, rvalid}, 32'd0);
        chk("abort_rd_busy", {31'd0, bsy}, 32'd0);

        // Reset in WAIT cancels the pending write
        valid = 1'b1; mode = 1'b1; addr = 32'h0000_1000; wdata = 32'hFFFF_FFFF;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0;
        tick();
        do_read(32'h0000_1000, rd, e, got);
        chk("rst_wait_word0", rd, 32'h0101_0101);

        // Reset in RRESP
        valid = 1'b1; mode = 1'b0; addr = 32'h0000_1004; rready = 1'b0;
        tick(); tick(); tick();
        chk("rst_rd_rvalid_hi", {31'd0, rvalid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_rd_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rd_rdata", rdata, 32'd0);
        chk("rst_rd_busy", {31'd0, bsy}, 32'd0);
        rst = 1'b0; valid = 1'b0;
        tick();
        do_read(32'h0000_1004, rd, e, got);
        chk("rst_rd_reread", rd, 32'hDEAD_BEEF);

        // Zero-latency instance: BUS_valid held after wready stays in DONE
        p = 0;
        valid0 = 1'b1; mode0 = 1'b1; addr0 = 32'h0000_1010; wdata0 = 32'hCAFE_F00D;
        tick();
        chk("z_wready_e0", {31'd0, wready0}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wready0) p++;
        end
        chk("z_no_second_write", p, 32'd0);
        chk("z_done_busy", {31'd0, bsy0}, 32'd1);
        wdata0 = 32'h5555_5555;
        valid0 = 1'b0;
        tick();
        chk("z_idle_busy", {31'd0, bsy0}, 32'd0);
        valid0 = 1'b1; mode0 = 1'b0; rready0 = 1'b1;
        tick();
        chk("z_rd_rvalid", {31'd0, rvalid0}, 32'd1);
        chk("z_rd_rdata", rdata0, 32'hCAFE_F00D);
        tick();
        chk("z_rd_rvalid_drop", {31'd0, rvalid0}, 32'd0);
        valid0 = 1'b0; rready0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
